// File: rtl/umi_port_arbiter_pkg.sv
// Shared encodings for the UMI output-port arbiter: arbitration modes,
// the EOM bit position in the UMI command and the lock-state enum.
package umi_arb_pkg;

  localparam logic [1:0] ARB_FIXED   = 2'b00;
  localparam logic [1:0] ARB_RR      = 2'b01;
  localparam int         UMI_EOM_BIT = 22;

  typedef enum logic {
    ARB   = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/umi_port_arbiter_if.sv
// Request/grant bundle between the N switch inputs and one arbitrated output.
// slave is the arbiter side, master is the requester/downstream side.
interface umi_port_arbiter_if #(
  parameter int N  = 4,
  parameter int CW = 32
);

  logic [N-1:0]    req_valid;
  logic [N*CW-1:0] req_cmd;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output req_valid, req_cmd, out_ready,
    input  req_ready, grant, out_valid
  );

  modport slave (
    input  req_valid, req_cmd, out_ready,
    output req_ready, grant, out_valid
  );

endinterface

// File: rtl/umi_port_arbiter_rotpri.sv
// Rotating priority encoder: one-hot grant of the first set request bit
// found searching upward from base, wrapping at N-1.
module umi_arb_rotpri #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  gnt
);

  // Scan from the far end back toward base so the closest hit is written last.
  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/umi_port_arbiter.sv
// Per-output-port scheduler: grants one UMI requester at a time, holds the
// grant across backpressure and locks it for multi-beat messages until EOM.
module umi_port_arbiter
  import umi_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int CW      = 32,
  parameter int MAXWAIT = 15,
  parameter int WW      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          arbmode,
  input  logic [N-1:0]        arbmask,
  umi_port_arbiter_if.slave   bus,
  output logic                owner_active
);

  localparam int IW = $clog2(N);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [WW-1:0] wait_q [N];
  logic [WW-1:0] wait_d [N];

  logic [N-1:0]  elig, starve, eom_vec;
  logic [N-1:0]  g_fix, g_starve, g_rr, arb_gnt, gnt;
  logic [IW-1:0] gnt_idx;
  logic          fixed_mode, xfer, eom_x, msg_done;

  always_comb begin
    elig    = bus.req_valid & ~arbmask;
    starve  = '0;
    eom_vec = '0;
    for (int i = 0; i < N; i++) begin
      starve[i]  = elig[i] && (wait_q[i] == WW'(MAXWAIT));
      eom_vec[i] = bus.req_cmd[i*CW + UMI_EOM_BIT];
    end
  end

  umi_arb_rotpri #(.N(N), .IW(IW)) u_fix (
    .req  (elig),
    .base ('0),
    .gnt  (g_fix)
  );

  umi_arb_rotpri #(.N(N), .IW(IW)) u_starve (
    .req  (starve),
    .base ('0),
    .gnt  (g_starve)
  );

  umi_arb_rotpri #(.N(N), .IW(IW)) u_rr (
    .req  (elig),
    .base (rr_ptr_q),
    .gnt  (g_rr)
  );

  // Reset gates the grant directly so no requester sees ready while held in reset.
  always_comb begin
    fixed_mode = (arbmode == ARB_FIXED);
    if (fixed_mode) arb_gnt = (|starve) ? g_starve : g_fix;
    else            arb_gnt = g_rr;

    gnt = '0;
    if (!reset) begin
      if (state_q == OWNED) gnt[owner_q] = 1'b1;
      else                  gnt = arb_gnt;
    end

    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = IW'(i);
    end
  end

  assign bus.grant     = gnt;
  assign bus.req_ready = gnt & {N{bus.out_ready}};
  assign bus.out_valid = |(gnt & bus.req_valid);
  assign xfer          = bus.out_valid & bus.out_ready;
  assign eom_x         = |(gnt & eom_vec);
  assign msg_done      = xfer & eom_x;
  assign owner_active  = (state_q == OWNED);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB: begin
        if ((|gnt) && !msg_done) begin
          state_d = OWNED;
          owner_d = gnt_idx;
        end
      end
      OWNED: begin
        if (msg_done) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (msg_done) begin
      if (int'(gnt_idx) == N - 1) rr_ptr_d = '0;
      else                        rr_ptr_d = gnt_idx + IW'(1);
    end
  end

  // Wait counters age only on completed messages; masked-but-valid requesters hold.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wait_d[i] = wait_q[i];
      if (!fixed_mode) begin
        wait_d[i] = '0;
      end else if (msg_done) begin
        if (gnt[i] || !bus.req_valid[i]) begin
          wait_d[i] = '0;
        end else if (elig[i] && (wait_q[i] != WW'(MAXWAIT))) begin
          wait_d[i] = wait_q[i] + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < N; i++) wait_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N; i++) wait_q[i] <= wait_d[i];
    end
  end

endmodule

// File: tb/tb_umi_port_arbiter.sv
// Scoreboard bench for umi_port_arbiter: a queue-based reference model predicts
// grant/ready/valid/lock per cycle; a negedge monitor pops and compares.
module tb_umi_port_arbiter;

  localparam int N    = 4;
  localparam int CW   = 32;
  localparam int MAXW = 3;

  typedef struct {
    logic [N-1:0] grant;
    logic [N-1:0] ready;
    logic         ov;
    logic         oa;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] arbmode;
  logic [N-1:0] arbmask;
  logic       owner_active;

  umi_port_arbiter_if #(.N(N), .CW(CW)) bus ();

  umi_port_arbiter #(.N(N), .CW(CW), .MAXWAIT(MAXW), .WW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .arbmode      (arbmode),
    .arbmask      (arbmask),
    .bus          (bus),
    .owner_active (owner_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  bit m_locked;
  int m_owner;
  int m_rr;
  int m_wait [N];

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_rr     = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  task automatic drive(input logic rst_i, input logic [1:0] mode,
                       input logic [N-1:0] mask, input logic [N-1:0] valid,
                       input logic [N-1:0] eom, input logic rdy);
    logic [N*CW-1:0] cmd;
    logic [N-1:0]    elig;
    exp_t            e;
    int              gi;
    bit              xfer, done;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      cmd[i*CW +: CW] = $urandom;
      cmd[i*CW + 22]  = eom[i];
    end
    reset         = rst_i;
    arbmode       = mode;
    arbmask       = mask;
    bus.req_valid = valid;
    bus.req_cmd   = cmd;
    bus.out_ready = rdy;

    e.grant = '0;
    gi = -1;
    if (rst_i) begin
      model_reset();
    end else if (m_locked) begin
      gi = m_owner;
    end else begin
      elig = valid & ~mask;
      if (mode == 2'b00) begin
        for (int i = N - 1; i >= 0; i--)
          if (elig[i]) gi = i;
        for (int i = N - 1; i >= 0; i--)
          if (elig[i] && m_wait[i] == MAXW) gi = i;
      end else begin
        for (int k = N - 1; k >= 0; k--)
          if (elig[(m_rr + k) % N]) gi = (m_rr + k) % N;
      end
    end
    if (gi >= 0) e.grant[gi] = 1'b1;
    e.ready = rdy ? e.grant : '0;
    e.ov    = (gi >= 0) && valid[gi];
    e.oa    = m_locked;
    sb.push_back(e);

    if (!rst_i) begin
      elig = valid & ~mask;
      xfer = e.ov && rdy;
      done = xfer && eom[gi];
      if (mode != 2'b00) begin
        for (int i = 0; i < N; i++) m_wait[i] = 0;
      end else if (done) begin
        for (int i = 0; i < N; i++) begin
          if (i == gi || !valid[i]) m_wait[i] = 0;
          else if (elig[i] && m_wait[i] < MAXW) m_wait[i] = m_wait[i] + 1;
        end
      end
      if (done) begin
        m_locked = 0;
        m_rr     = (gi + 1) % N;
      end else if (gi >= 0 && !m_locked) begin
        m_locked = 1;
        m_owner  = gi;
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (bus.grant !== e.grant) begin
        miscompares++;
        $display("FAIL grant @%0t: got %b expected %b", $time, bus.grant, e.grant);
      end
      if (bus.req_ready !== e.ready) begin
        miscompares++;
        $display("FAIL req_ready @%0t: got %b expected %b", $time, bus.req_ready, e.ready);
      end
      if (bus.out_valid !== e.ov) begin
        miscompares++;
        $display("FAIL out_valid @%0t: got %b expected %b", $time, bus.out_valid, e.ov);
      end
      if (owner_active !== e.oa) begin
        miscompares++;
        $display("FAIL owner_active @%0t: got %b expected %b", $time, owner_active, e.oa);
      end
    end
  end

  initial begin
    logic [1:0]   mode;
    logic [N-1:0] mask;
    int           waited;
    reset         = 1'b1;
    arbmode       = 2'b00;
    arbmask       = '0;
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset with all valid, then same-cycle grant after release
    drive(1, 2'b00, 4'b0000, 4'b1111, 4'b1111, 1);
    drive(1, 2'b00, 4'b0000, 4'b1111, 4'b1111, 1);
    drive(0, 2'b00, 4'b0000, 4'b1111, 4'b1111, 0);
    drive(0, 2'b00, 4'b0000, 4'b1111, 4'b1111, 1);

    // Round-robin sweep
    drive(1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 1);
    repeat (8) drive(0, 2'b01, 4'b0000, 4'b1111, 4'b1111, 1);

    // Backpressure hold
    drive(1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 1);
    repeat (3) drive(0, 2'b01, 4'b0000, 4'b0110, 4'b1111, 0);
    drive(0, 2'b01, 4'b0000, 4'b0110, 4'b1111, 1);
    drive(0, 2'b01, 4'b0000, 4'b0110, 4'b1111, 1);

    // Message lock against a higher-priority requester
    drive(1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1);
    drive(0, 2'b00, 4'b0000, 4'b0100, 4'b0001, 1);
    drive(0, 2'b00, 4'b0000, 4'b0101, 4'b0001, 1);
    drive(0, 2'b00, 4'b0000, 4'b0101, 4'b0101, 1);
    drive(0, 2'b00, 4'b0000, 4'b0001, 4'b0001, 1);

    // Starvation boost
    drive(1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1);
    repeat (10) drive(0, 2'b00, 4'b0000, 4'b1001, 4'b1111, 1);

    // Mask for new arbitration, but not for an owner mid-message
    drive(1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1);
    drive(0, 2'b00, 4'b0001, 4'b0011, 4'b1111, 1);
    drive(0, 2'b00, 4'b0000, 4'b0001, 4'b0000, 1);
    drive(0, 2'b01, 4'b0001, 4'b0011, 4'b0000, 1);
    drive(0, 2'b00, 4'b0001, 4'b0011, 4'b0001, 1);
    drive(0, 2'b00, 4'b0001, 4'b0011, 4'b0011, 1);

    // Reset mid-message drops the lock
    drive(0, 2'b01, 4'b0000, 4'b0100, 4'b0000, 1);
    drive(1, 2'b01, 4'b0000, 4'b0100, 4'b0000, 1);
    drive(0, 2'b01, 4'b0000, 4'b0101, 4'b1111, 1);

    // Randomised traffic
    mode = 2'b00;
    mask = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)  mask = 4'($urandom) & 4'($urandom);
      drive(($urandom_range(0, 79) == 0), mode, mask, 4'($urandom),
            4'($urandom), ($urandom_range(0, 3) != 0));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/umi_port_arbiter.md
Name: umi_port_arbiter

Overview:
- Per-output-port scheduler for the UMI switch. Shares one downstream UMI output among N requesting inputs.
- Grants exactly one requester at a time and holds the grant under backpressure. Locks the grant for multi-transaction messages until EOM.
- Supports fixed-priority and round-robin modes, a requester mask, and starvation boost in fixed-priority mode.
- One instance per switch output; the switch muxes cmd/dstaddr/srcaddr/data using the one-hot grant.

Parameters:
- N, 4, number of requesting inputs (2..16).
- CW, 32, UMI command width.
- MAXWAIT, 15, fixed-priority starvation threshold in lost arbitration rounds (1..255).
- WW, 8, wait-counter width; must hold MAXWAIT.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- arbmode  input  2  00 fixed priority (lowest index wins), 01 round-robin, 1x same as round-robin.
- arbmask  input  N  1 = requester excluded from new arbitration.
- req_valid  input  N  per-requester valid (umi_in_valid row for this output).
- req_cmd  input  N*CW  per-requester UMI cmd; bit 22 = EOM.
- req_ready  output  N  grant & {N{out_ready}}.
- grant  output  N  one-hot or zero; selects the datapath mux.
- out_valid  input-derived output  1  |(grant & req_valid).
- out_ready  input  1  downstream ready.
- owner_active  output  1  high while in the OWNED state (debug/status).

Behaviour:
- Reset (async, active-high): state=ARB, rr_ptr=0, owner=0, all wait counters=0. grant=0, req_ready=0, out_valid=0 while reset is asserted.
- Transfer: a cycle with out_valid & out_ready. eom_x = req_cmd[owner*CW+22] of the granted requester.
- State ARB:
  - Eligible set E = req_valid & ~arbmask.
  - Grant is combinational, same cycle (zero latency).
  - Fixed mode: if any eligible requester has wait==MAXWAIT, grant the lowest such index; else grant the lowest index in E.
  - RR mode: grant the first set bit of E searching from rr_ptr upward, wrapping at N-1 to 0.
  - E==0: grant=0.
- Transitions:
  - ARB -> OWNED (owner := granted index) when grant!=0 and NOT (transfer & eom_x), i.e. backpressured or a non-EOM transfer.
  - ARB stays ARB on a transfer with EOM set.
  - OWNED: grant = onehot(owner), independent of arbmask, arbmode and other requests.
  - OWNED -> ARB on a transfer with eom_x=1.
  - OWNED stays OWNED otherwise, including when the owner deasserts valid mid-message. That case is a protocol violation; it is held, not aborted.
- rr_ptr updates only on a transfer with eom_x=1: rr_ptr := (granted index + 1) mod N. It is not updated on non-EOM beats.
- Wait counters (fixed mode only) update on each transfer with EOM:
  - Each eligible-but-not-granted requester increments, saturating at MAXWAIT.
  - The granted requester clears to 0.
  - Counters for requesters with valid low are cleared.
  - In RR mode counters are held at 0.
- arbmode or arbmask change in OWNED: no effect until return to ARB.
- Simultaneous events:
  - The same-cycle transfer with EOM and a new request resolves in ARB on the following cycle with the updated rr_ptr.
  - Single requester repeatedly sending EOM packets: granted every cycle, no bubbles.
- Throughput: one transfer per cycle whenever out_ready=1 and a granted requester is valid.
- Reset mid-message: lock dropped immediately (async); arbitration restarts from rr_ptr=0 after reset release.

Decomposition:
- Package umi_arb_pkg holds:
  - arbmode encodings ARB_FIXED=2'b00, ARB_RR=2'b01.
  - UMI_EOM_BIT=22.
  - state enum {ARB, OWNED}.
- Sub-module umi_arb_rotpri: parameterised N-bit rotating priority encoder (req, base pointer -> one-hot grant).
  - Fixed mode calls it with base 0.
  - Starvation path calls it with base 0 on the mask wait==MAXWAIT.

Test Plan:
- Reset/idle:
  - Stimulus: assert reset with req_valid=4'b1111.
  - Required: grant=0, req_ready=0. After release, fixed mode grants 4'b0001 in the same cycle.
- Round-robin:
  - Stimulus: arbmode=01, all four valid with EOM=1, out_ready=1 for 8 cycles.
  - Required: grant sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Backpressure hold:
  - Stimulus: RR, req 1 and 2 valid, out_ready=0 for 3 cycles, then 1.
  - Required: grant stays 0010 for all 4 cycles; transfer on cycle 4; next grant 0100.
- Message lock:
  - Stimulus: requester 2 sends 3 beats with EOM=0,0,1; requester 0 is valid throughout in fixed mode.
  - Required: grant=0100 for all 3 beats despite requester 0's higher priority; then 0001.
- Starvation:
  - Stimulus: fixed mode, MAXWAIT=3, requesters 0 and 3 continuously valid with EOM=1.
  - Required: grants 0001 x3, then 1000 once, then the pattern repeats.
- Mask:
  - Stimulus: arbmask=0001 with requesters 0 and 1 valid in fixed mode.
  - Required: grant=0010. Setting the mask while requester 0 owns mid-message does not revoke its grant until EOM.
